// File: rtl/cpu_core_pkg.sv
// Shared opcodes, FSM state encodings and instruction field offsets for the parametrised CPU core.
// Instruction layout is {op, rd, rs, imm}, imm in the low DATA_W bits.
package cpu_core_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
   localparam logic [OP_W-1:0] OP_MOV  = 4'h2;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h4;
   localparam logic [OP_W-1:0] OP_AND  = 4'h5;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h6;
   localparam logic [OP_W-1:0] OP_IN   = 4'h7;
   localparam logic [OP_W-1:0] OP_OUT  = 4'h8;
   localparam logic [OP_W-1:0] OP_JMP  = 4'h9;
   localparam logic [OP_W-1:0] OP_JZ   = 4'hA;
   localparam logic [OP_W-1:0] OP_JC   = 4'hB;
   localparam logic [OP_W-1:0] OP_JB   = 4'hC;
   localparam logic [OP_W-1:0] OP_SGP  = 4'hD;
   localparam logic [OP_W-1:0] OP_SHR  = 4'hE;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_WAIT_IN = 2'd1,
      ST_HALT    = 2'd2
   } state_t;

   function automatic int rs_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int rd_lsb(input int reg_aw, input int data_w);
      return data_w + reg_aw;
   endfunction

   function automatic int op_lsb(input int reg_aw, input int data_w);
      return data_w + 2 * reg_aw;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the CPU core. Ops without arithmetic pass b through,
// so LDI/MOV/IN share the same zero-flag path as the real ALU ops.
module cpu_alu
   import cpu_core_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  logic [OP_W-1:0]   op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              z,
   output logic              c
);

   always_comb begin
      result = b;
      c      = 1'b0;
      case (op)
         OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
         OP_SUB: begin
            result = a - b;
            c      = (a < b);
         end
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         OP_SHR: begin
            result = a >> 1;
            c      = a[0];
         end
         default: ;
      endcase
      z = (result == '0);
   end

endmodule

// File: rtl/cpu_core_param.sv
// Parametrised accumulator/register CPU core: one instruction per tick from a combinational ROM,
// with a prescaler for slow on-board stepping and an IN handshake that can stall the pipeline.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_RUN     | execute the instruction at IP on every tick
//   ST_WAIT_IN | IN issued without Sample; IP held until Sample=1
//   ST_HALT    | terminal, outputs frozen, only Reset leaves
module cpu_core_param
   import cpu_core_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int REG_AW    = 2,
   parameter int GPO_W     = 6,
   parameter int BTN_W     = 3,
   parameter int SLOW_LOG2 = 20,
   parameter int INSTR_W   = OP_W + 2 * REG_AW + DATA_W
)(
   input  logic               Clock,
   input  logic               Reset,
   input  logic [INSTR_W-1:0] Instr,
   input  logic [DATA_W-1:0]  Din,
   input  logic               Sample,
   input  logic [BTN_W-1:0]   Btns,
   input  logic               Turbo,
   output logic [ADDR_W-1:0]  IP,
   output logic [DATA_W-1:0]  Dout,
   output logic               Dval,
   output logic [GPO_W-1:0]   GPO,
   output logic [3:0]         Debug
);

   localparam int OP_LSB = op_lsb(REG_AW, DATA_W);
   localparam int RD_LSB = rd_lsb(REG_AW, DATA_W);
   localparam int RS_LSB = rs_lsb(DATA_W);
   localparam int NREGS  = 2 ** REG_AW;

   logic [OP_W-1:0]   op;
   logic [REG_AW-1:0] rd;
   logic [REG_AW-1:0] rs;
   logic [DATA_W-1:0] imm;

   assign op  = Instr[OP_LSB +: OP_W];
   assign rd  = Instr[RD_LSB +: REG_AW];
   assign rs  = Instr[RS_LSB +: REG_AW];
   assign imm = Instr[DATA_W-1:0];

   state_t            state, state_nxt;
   logic [DATA_W-1:0] regs [NREGS];
   logic              z_flag, c_flag;
   logic [REG_AW-1:0] pend_rd;

   // Prescaler restarts whenever Turbo changes so the slow period is always a full one.
   logic [SLOW_LOG2-1:0] presc;
   logic                 turbo_q;
   logic                 tick;

   assign tick = Turbo | ((Turbo == turbo_q) && (presc == '1));

   always_ff @(posedge Clock) begin
      if (Reset) begin
         presc   <= '0;
         turbo_q <= Turbo;
      end else if (Turbo != turbo_q) begin
         presc   <= '0;
         turbo_q <= Turbo;
      end else if (!Turbo) begin
         presc   <= presc + SLOW_LOG2'(1);
      end
   end

   logic [DATA_W-1:0] rd_val, rs_val;
   assign rd_val = regs[rd];
   assign rs_val = regs[rs];

   logic btn_hit;
   always_comb begin
      btn_hit = 1'b0;
      for (int i = 0; i < BTN_W; i++)
         if (int'(rs) == i) btn_hit = Btns[i];
   end

   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_b, alu_res;
   logic              alu_z, alu_c;

   assign alu_op = (state == ST_WAIT_IN) ? OP_IN : op;

   always_comb begin
      alu_b = rs_val;
      if (alu_op == OP_LDI)     alu_b = imm;
      else if (alu_op == OP_IN) alu_b = Din;
   end

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (alu_op),
      .a      (rd_val),
      .b      (alu_b),
      .result (alu_res),
      .z      (alu_z),
      .c      (alu_c)
   );

   always_ff @(posedge Clock) begin
      if (Reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (tick && op == OP_HALT)             state_nxt = ST_HALT;
            else if (tick && op == OP_IN && !Sample) state_nxt = ST_WAIT_IN;
         end
         ST_WAIT_IN: if (Sample) state_nxt = ST_RUN;
         ST_HALT:    state_nxt = ST_HALT;
         default:    state_nxt = ST_RUN;
      endcase
   end

   logic [ADDR_W-1:0] ip_nxt;
   logic [REG_AW-1:0] wr_addr;
   logic              wr_en, z_en, c_en, out_en, gpo_en, pend_en;

   always_comb begin
      ip_nxt  = IP;
      wr_addr = rd;
      wr_en   = 1'b0;
      z_en    = 1'b0;
      c_en    = 1'b0;
      out_en  = 1'b0;
      gpo_en  = 1'b0;
      pend_en = 1'b0;
      case (state)
         ST_RUN: if (tick) begin
            ip_nxt = IP + ADDR_W'(1);
            case (op)
               OP_LDI: begin wr_en = 1'b1; z_en = 1'b1; end
               OP_MOV: wr_en = 1'b1;
               OP_ADD, OP_SUB, OP_SHR: begin
                  wr_en = 1'b1; z_en = 1'b1; c_en = 1'b1;
               end
               OP_AND, OP_XOR: begin wr_en = 1'b1; z_en = 1'b1; end
               OP_IN: begin
                  if (Sample) begin
                     wr_en = 1'b1; z_en = 1'b1;
                  end else begin
                     ip_nxt = IP; pend_en = 1'b1;
                  end
               end
               OP_OUT:  out_en = 1'b1;
               OP_JMP:  ip_nxt = imm[ADDR_W-1:0];
               OP_JZ:   if (z_flag)  ip_nxt = imm[ADDR_W-1:0];
               OP_JC:   if (c_flag)  ip_nxt = imm[ADDR_W-1:0];
               OP_JB:   if (btn_hit) ip_nxt = imm[ADDR_W-1:0];
               OP_SGP:  gpo_en = 1'b1;
               OP_HALT: ip_nxt = IP;
               default: ;
            endcase
         end
         ST_WAIT_IN: if (Sample) begin
            ip_nxt  = IP + ADDR_W'(1);
            wr_addr = pend_rd;
            wr_en   = 1'b1;
            z_en    = 1'b1;
         end
         default: ;
      endcase
   end

   logic [GPO_W+DATA_W-1:0] gpo_ext;
   assign gpo_ext = {{GPO_W{1'b0}}, rs_val};

   always_ff @(posedge Clock) begin
      if (Reset) begin
         IP      <= '0;
         Dout    <= '0;
         Dval    <= 1'b0;
         GPO     <= '0;
         z_flag  <= 1'b0;
         c_flag  <= 1'b0;
         pend_rd <= '0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         IP   <= ip_nxt;
         Dval <= out_en;
         if (out_en)  Dout    <= rs_val;
         if (gpo_en)  GPO     <= gpo_ext[GPO_W-1:0];
         if (wr_en)   regs[wr_addr] <= alu_res;
         if (z_en)    z_flag  <= alu_z;
         if (c_en)    c_flag  <= alu_c;
         if (pend_en) pend_rd <= rd;
      end
   end

   assign Debug = {c_flag, z_flag, state};

endmodule

// File: tb/tb_cpu_core_param.sv
// Self-checking bench for cpu_core_param: table of ALU/flag vectors plus hand-written
// sequences for jumps, IN stalls, prescaler timing, HALT and reset; Dout stream via scoreboard.
module tb_cpu_core_param;

   localparam logic [3:0] T_NOP = 4'h0, T_LDI = 4'h1, T_MOV = 4'h2, T_ADD = 4'h3,
                          T_SUB = 4'h4, T_AND = 4'h5, T_XOR = 4'h6, T_IN  = 4'h7,
                          T_OUT = 4'h8, T_JMP = 4'h9, T_JZ  = 4'hA, T_JC  = 4'hB,
                          T_JB  = 4'hC, T_SGP = 4'hD, T_SHR = 4'hE, T_HLT = 4'hF;

   logic        Clock = 1'b0;
   logic        Reset, Sample, Turbo;
   logic [15:0] Instr;
   logic [7:0]  Din, IP, Dout;
   logic [2:0]  Btns;
   logic        Dval;
   logic [5:0]  GPO;
   logic [3:0]  Debug;

   logic [15:0] rom [256];
   logic [7:0]  sb [$];
   int          n_cmp = 0;
   int          n_err = 0;

   assign Instr = rom[IP];

   always #5 Clock = ~Clock;

   cpu_core_param #(
      .DATA_W(8), .ADDR_W(8), .REG_AW(2), .GPO_W(6), .BTN_W(3), .SLOW_LOG2(3)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Instr(Instr), .Din(Din), .Sample(Sample),
      .Btns(Btns), .Turbo(Turbo), .IP(IP), .Dout(Dout), .Dval(Dval),
      .GPO(GPO), .Debug(Debug)
   );

   function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
      return {op, rd, rs, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      run(2);
      Reset = 1'b0;
   endtask

   // Dout stream monitor: every Dval pulse must match the next expected OUT value.
   always @(posedge Clock) begin
      #1;
      if (Dval) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL dval_unexpected: got Dout=%0h expected no Dval", Dout);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            if (Dout !== e) begin
               n_err++;
               $display("FAIL dout_stream: got %0h expected %0h", Dout, e);
            end
         end
      end
   end

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       z;
      logic       c;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{T_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
      vecs[1] = '{T_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
      vecs[2] = '{T_ADD, 8'h80, 8'h90, 8'h10, 1'b0, 1'b1};
      vecs[3] = '{T_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1};
      vecs[4] = '{T_SUB, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0};
      vecs[5] = '{T_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{T_XOR, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0};
      vecs[7] = '{T_SHR, 8'h03, 8'h00, 8'h01, 1'b0, 1'b1};
      vecs[8] = '{T_SHR, 8'h01, 8'h55, 8'h00, 1'b1, 1'b1};
      vecs[9] = '{T_MOV, 8'h11, 8'h22, 8'h22, 1'b0, 1'b0};

      Reset = 1'b1; Turbo = 1'b1; Sample = 1'b0; Din = 8'h00; Btns = 3'b000;
      clear_rom();

      // Reset state, then first fetch
      run(2);
      check("rst_ip", 32'(IP), 32'h0);
      check("rst_gpo", 32'(GPO), 32'h0);
      check("rst_dout", 32'(Dout), 32'h0);
      check("rst_dval", 32'(Dval), 32'h0);
      check("rst_debug", 32'(Debug), 32'h0);
      Reset = 1'b0;
      run(1);
      check("first_ip", 32'(IP), 32'h1);

      // ALU / flag vectors: LDI R0,a; LDI R1,b; op R0,R1; OUT R0; HALT
      for (int i = 0; i < 10; i++) begin
         clear_rom();
         rom[0] = enc(T_LDI, 2'd0, 2'd0, vecs[i].a);
         rom[1] = enc(T_LDI, 2'd1, 2'd0, vecs[i].b);
         rom[2] = enc(vecs[i].op, 2'd0, 2'd1, 8'h00);
         rom[3] = enc(T_OUT, 2'd0, 2'd0, 8'h00);
         rom[4] = enc(T_HLT, 2'd0, 2'd0, 8'h00);
         do_reset();
         sb.push_back(vecs[i].res);
         run(3);
         check($sformatf("vec%0d_flags", i), 32'(Debug), 32'({vecs[i].c, vecs[i].z, 2'b00}));
         run(1);
         check($sformatf("vec%0d_dout", i), 32'(Dout), 32'(vecs[i].res));
         run(1);
         check($sformatf("vec%0d_halt", i), 32'(Debug[1:0]), 32'h2);
         check($sformatf("vec%0d_ip", i), 32'(IP), 32'h4);
      end

      // Conditional jumps on C and Z
      clear_rom();
      rom[8'h00] = enc(T_LDI, 2'd0, 2'd0, 8'hFF);
      rom[8'h01] = enc(T_LDI, 2'd1, 2'd0, 8'h01);
      rom[8'h02] = enc(T_ADD, 2'd0, 2'd1, 8'h00);
      rom[8'h03] = enc(T_JC,  2'd0, 2'd0, 8'h10);
      rom[8'h10] = enc(T_JZ,  2'd0, 2'd0, 8'h20);
      rom[8'h20] = enc(T_LDI, 2'd3, 2'd0, 8'h01);
      rom[8'h21] = enc(T_JZ,  2'd0, 2'd0, 8'h40);
      do_reset();
      run(4);
      check("jc_taken", 32'(IP), 32'h10);
      run(1);
      check("jz_taken", 32'(IP), 32'h20);
      run(2);
      check("jz_not_taken", 32'(IP), 32'h22);

      // IN stall, OUT pulse, SGP
      clear_rom();
      rom[0] = enc(T_IN,  2'd2, 2'd0, 8'h00);
      rom[1] = enc(T_OUT, 2'd0, 2'd2, 8'h00);
      rom[2] = enc(T_SGP, 2'd0, 2'd2, 8'h00);
      rom[3] = enc(T_HLT, 2'd0, 2'd0, 8'h00);
      do_reset();
      for (int k = 0; k < 5; k++) begin
         run(1);
         check($sformatf("stall%0d_ip", k), 32'(IP), 32'h0);
         check($sformatf("stall%0d_state", k), 32'(Debug[1:0]), 32'h1);
      end
      Din = 8'h5A; Sample = 1'b1;
      sb.push_back(8'h5A);
      run(1);
      Sample = 1'b0; Din = 8'h00;
      check("in_done_ip", 32'(IP), 32'h1);
      check("in_done_state", 32'(Debug[1:0]), 32'h0);
      run(1);
      check("out_dval_hi", 32'(Dval), 32'h1);
      check("out_dout", 32'(Dout), 32'h5A);
      run(1);
      check("out_dval_lo", 32'(Dval), 32'h0);
      check("sgp_gpo", 32'(GPO), 32'h1A);
      run(4);
      check("halt_ip", 32'(IP), 32'h3);
      check("halt_gpo", 32'(GPO), 32'h1A);
      check("halt_dout", 32'(Dout), 32'h5A);

      // IN with Sample already high completes immediately, zero sets Z
      clear_rom();
      rom[0] = enc(T_IN, 2'd1, 2'd0, 8'h00);
      do_reset();
      Sample = 1'b1; Din = 8'h00;
      run(1);
      Sample = 1'b0;
      check("in_fast_ip", 32'(IP), 32'h1);
      check("in_fast_debug", 32'(Debug), 32'h4);

      // JB loop, out-of-range button index, IP wrap
      clear_rom();
      rom[0] = enc(T_JB,  2'd0, 2'd1, 8'h00);
      rom[1] = enc(T_JB,  2'd0, 2'd3, 8'h00);
      rom[2] = enc(T_JMP, 2'd0, 2'd0, 8'hFF);
      Btns = 3'b010;
      do_reset();
      run(3);
      check("jb_loop", 32'(IP), 32'h0);
      Btns = 3'b000;
      run(1);
      check("jb_fall", 32'(IP), 32'h1);
      Btns = 3'b111;
      run(1);
      check("jb_rs_oob", 32'(IP), 32'h2);
      run(1);
      check("jmp_ff", 32'(IP), 32'hFF);
      run(1);
      check("ip_wrap", 32'(IP), 32'h0);
      Btns = 3'b000;

      // Slow ticks: one instruction per 8 cycles; Turbo toggle restarts the period
      clear_rom();
      Turbo = 1'b0;
      do_reset();
      run(7);
      check("slow_ip_7", 32'(IP), 32'h0);
      run(1);
      check("slow_ip_8", 32'(IP), 32'h1);
      run(8);
      check("slow_ip_16", 32'(IP), 32'h2);
      Turbo = 1'b1;
      run(1);
      check("turbo_on", 32'(IP), 32'h3);
      Turbo = 1'b0;
      run(8);
      check("turbo_off_8", 32'(IP), 32'h3);
      run(1);
      check("turbo_off_9", 32'(IP), 32'h4);
      Turbo = 1'b1;

      // HALT then Reset
      clear_rom();
      rom[1] = enc(T_HLT, 2'd0, 2'd0, 8'h00);
      do_reset();
      run(5);
      check("halt_hold_ip", 32'(IP), 32'h1);
      check("halt_state", 32'(Debug[1:0]), 32'h2);
      Reset = 1'b1;
      run(1);
      check("halt_rst_ip", 32'(IP), 32'h0);
      check("halt_rst_debug", 32'(Debug), 32'h0);
      Reset = 1'b0;

      // Reset in the middle of a stalled IN discards it
      clear_rom();
      rom[0] = enc(T_IN, 2'd0, 2'd0, 8'h00);
      do_reset();
      run(2);
      check("stall_state", 32'(Debug[1:0]), 32'h1);
      Reset = 1'b1;
      run(1);
      check("stall_rst_debug", 32'(Debug), 32'h0);
      check("stall_rst_dval", 32'(Dval), 32'h0);
      Reset = 1'b0;
      run(2);

      check("sb_empty", 32'(sb.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
